// File: rtl/fpu_pkg.sv
// Shared types for the FP sign-injection issue path: op encoding, funct3 constants,
// the queued result record and the funct3 decode helpers.
package fpu_pkg;

  localparam int SGNJ_RD_W = 5;

  localparam logic [2:0] FUNCT3_FSGNJ  = 3'b000;
  localparam logic [2:0] FUNCT3_FSGNJN = 3'b001;
  localparam logic [2:0] FUNCT3_FSGNJX = 3'b010;

  typedef enum logic [1:0] {
    SGNJ  = 2'b00,
    SGNJN = 2'b01,
    SGNJX = 2'b10
  } sgnj_op_e;

  typedef struct packed {
    logic [31:0]          data;
    logic [SGNJ_RD_W-1:0] rd;
    logic                 illegal;
  } sgnj_res_t;

  // Illegal encodings fall back to SGNJ so the unit never sees op 11.
  function automatic sgnj_op_e funct3_to_op(input logic [2:0] funct3);
    sgnj_op_e op;
    case (funct3)
      FUNCT3_FSGNJN: op = SGNJN;
      FUNCT3_FSGNJX: op = SGNJX;
      default:       op = SGNJ;
    endcase
    return op;
  endfunction

  function automatic logic funct3_illegal(input logic [2:0] funct3);
    return !((funct3 == FUNCT3_FSGNJ) || (funct3 == FUNCT3_FSGNJN) ||
             (funct3 == FUNCT3_FSGNJX));
  endfunction

endpackage

// File: rtl/fpu_sgnj_issue_if.sv
// Handshake bundle of the sign-injection issue block: decode input, sign-injection
// unit link and writeback output. master is the issue block, slave its surroundings.
interface fpu_sgnj_issue_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [31:0]     in_rs1;
  logic [31:0]     in_rs2;
  logic [RD_W-1:0] in_rd;

  logic [31:0]     sgnj_rs1;
  logic [31:0]     sgnj_rs2;
  logic [1:0]      sgnj_op;
  logic [31:0]     sgnj_rd;

  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_illegal;

  modport master (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, sgnj_rd, wb_ready,
    output in_ready, sgnj_rs1, sgnj_rs2, sgnj_op, wb_valid, wb_data, wb_rd, wb_illegal
  );

  modport slave (
    output in_valid, in_funct3, in_rs1, in_rs2, in_rd, sgnj_rd, wb_ready,
    input  in_ready, sgnj_rs1, sgnj_rs2, sgnj_op, wb_valid, wb_data, wb_rd, wb_illegal
  );
endinterface

// File: rtl/fpu_res_fifo.sv
// Result queue between the issue register and FP writeback. A pop frees its slot in the
// same cycle, so push is accepted while full if the head is being consumed.
module fpu_res_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH    = 2,
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  sgnj_res_t           push_data,
  output logic                pop_valid,
  input  logic                pop_ready,
  output sgnj_res_t           pop_data,
  output logic [CNT_BITS-1:0] count
);

  sgnj_res_t           mem_q [DEPTH];
  sgnj_res_t           mem_d [DEPTH];
  sgnj_res_t           last_q, last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                push, pop;

  always_comb begin
    pop_valid  = (count_q != '0);
    pop        = pop_valid && pop_ready;
    push_ready = (count_q < CNT_BITS'(DEPTH)) || pop;
    push       = push_valid && push_ready;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

    // Remember the head as it leaves so an empty queue keeps presenting it.
    last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    pop_data = pop_valid ? mem_q[rd_ptr_q] : last_q;
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpu_sgnj_issue.sv
// Issue side of FSGNJ/FSGNJN/FSGNJX: registers decoded ops, drives the combinational
// sign-injection unit and queues its results for FP register-file writeback.
module fpu_sgnj_issue
  import fpu_pkg::*;
#(
  parameter int RD_W  = SGNJ_RD_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  fpu_sgnj_issue_if.master  bus,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic            iss_valid_q, iss_valid_d;
  sgnj_op_e        iss_op_q, iss_op_d;
  logic [31:0]     iss_rs1_q, iss_rs1_d;
  logic [31:0]     iss_rs2_q, iss_rs2_d;
  logic [RD_W-1:0] iss_rd_q, iss_rd_d;
  logic            iss_illegal_q, iss_illegal_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic                fifo_push_ready;
  logic [CNT_BITS-1:0] fifo_count;
  sgnj_res_t           push_res, head_res;
  logic                advance, accept, pop;

  always_comb begin
    advance = iss_valid_q && fifo_push_ready;
    accept  = bus.in_valid && bus.in_ready;
    pop     = bus.wb_valid && bus.wb_ready;

    iss_valid_d   = iss_valid_q;
    iss_op_d      = iss_op_q;
    iss_rs1_d     = iss_rs1_q;
    iss_rs2_d     = iss_rs2_q;
    iss_rd_d      = iss_rd_q;
    iss_illegal_d = iss_illegal_q;
    if (accept) begin
      iss_valid_d   = 1'b1;
      iss_op_d      = funct3_to_op(bus.in_funct3);
      iss_rs1_d     = bus.in_rs1;
      iss_rs2_d     = bus.in_rs2;
      iss_rd_d      = bus.in_rd;
      iss_illegal_d = funct3_illegal(bus.in_funct3);
    end else if (advance) begin
      iss_valid_d = 1'b0;
    end

    push_res.data    = iss_illegal_q ? 32'h0 : bus.sgnj_rd;
    push_res.rd      = SGNJ_RD_W'(iss_rd_q);
    push_res.illegal = iss_illegal_q;

    op_count_d = op_count_q + CNT_W'(pop);
  end

  assign bus.in_ready   = !iss_valid_q || advance;
  assign bus.sgnj_rs1   = iss_valid_q ? iss_rs1_q : 32'h0;
  assign bus.sgnj_rs2   = iss_valid_q ? iss_rs2_q : 32'h0;
  assign bus.sgnj_op    = iss_valid_q ? iss_op_q : SGNJ;
  assign bus.wb_data    = head_res.data;
  assign bus.wb_rd      = RD_W'(head_res.rd);
  assign bus.wb_illegal = head_res.illegal;
  assign busy           = iss_valid_q || (fifo_count != '0);
  assign op_count       = op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q   <= 1'b0;
      iss_op_q      <= SGNJ;
      iss_rs1_q     <= '0;
      iss_rs2_q     <= '0;
      iss_rd_q      <= '0;
      iss_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      iss_op_q      <= iss_op_d;
      iss_rs1_q     <= iss_rs1_d;
      iss_rs2_q     <= iss_rs2_d;
      iss_rd_q      <= iss_rd_d;
      iss_illegal_q <= iss_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  fpu_res_fifo #(
    .DEPTH(DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(iss_valid_q),
    .push_ready(fifo_push_ready),
    .push_data (push_res),
    .pop_valid (bus.wb_valid),
    .pop_ready (bus.wb_ready),
    .pop_data  (head_res),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fpu_sgnj_issue.sv
// Bench for fpu_sgnj_issue: directed ops with hand-computed results go into a scoreboard
// queue on acceptance; a monitor pops and compares on every writeback handshake.
module tb_fpu_sgnj_issue;
  import fpu_pkg::*;

  localparam int RD_W = 5;

  typedef struct {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic            ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] op_count;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_count = '0;

  fpu_sgnj_issue_if #(.RD_W(RD_W)) bus ();

  fpu_sgnj_issue #(
    .RD_W (RD_W),
    .DEPTH(2),
    .CNT_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational sign-injection unit.
  always_comb begin
    case (bus.sgnj_op)
      2'b00:   bus.sgnj_rd = {bus.sgnj_rs2[31], bus.sgnj_rs1[30:0]};
      2'b01:   bus.sgnj_rd = {~bus.sgnj_rs2[31], bus.sgnj_rs1[30:0]};
      2'b10:   bus.sgnj_rd = {bus.sgnj_rs1[31] ^ bus.sgnj_rs2[31], bus.sgnj_rs1[30:0]};
      default: bus.sgnj_rd = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the head against the scoreboard on each pop; reset flushes expectations.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_count = '0;
    end else if (bus.wb_valid && bus.wb_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_pop: got wb_rd %0d, expected no output", bus.wb_rd);
      end else begin
        e = sb.pop_front();
        check_output("wb_data", bus.wb_data, e.data);
        check_output("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
        check_output("wb_illegal", 32'(bus.wb_illegal), 32'(e.ill));
        check_output("op_count", 32'(op_count), 32'(exp_count));
        exp_count = exp_count + 16'd1;
      end
    end
  end

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'b000;
    bus.in_rs1    = 32'h0;
    bus.in_rs2    = 32'h0;
    bus.in_rd     = '0;
  endtask

  // Presents one op, waits (bounded) for acceptance and records its expected result.
  // Returns just after the accepting edge with in_valid still asserted.
  task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [RD_W-1:0] rd,
                                input logic [31:0] exp_data, input logic exp_ill,
                                output int waited);
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    waited        = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 for rd %0d, expected 1", rd);
    end else begin
      e.data = exp_data;
      e.rd   = rd;
      e.ill  = exp_ill;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_done", 32'(sb.size() == 0 && !busy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    set_idle();
    bus.wb_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_op_count", 32'(op_count), 32'd0);
    check_output("rst_wb_data", bus.wb_data, 32'h0);
    check_output("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check_output("rst_wb_illegal", 32'(bus.wb_illegal), 32'd0);
    check_output("rst_sgnj_rs1", bus.sgnj_rs1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fsgnj with two-cycle latency
    apply_stimulus(3'b000, 32'h3F80_0000, 32'h8000_0000, 5'd3, 32'hBF80_0000, 1'b0, w);
    set_idle();
    @(negedge clk);
    check_output("lat_cycle1_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("iss_sgnj_rs1", bus.sgnj_rs1, 32'h3F80_0000);
    check_output("iss_sgnj_op", 32'(bus.sgnj_op), 32'd0);
    @(negedge clk);
    check_output("lat_cycle2_wb_valid", 32'(bus.wb_valid), 32'd1);
    @(posedge clk);
    #1;

    // fsgnjn then fsgnjx back to back
    apply_stimulus(3'b001, 32'hBF80_0000, 32'h8000_0000, 5'd4, 32'h3F80_0000, 1'b0, w);
    apply_stimulus(3'b010, 32'hBF80_0000, 32'h8000_0000, 5'd5, 32'h3F80_0000, 1'b0, w);
    check_output("b2b_wait", 32'(w), 32'd0);

    // Illegal funct3
    apply_stimulus(3'b011, 32'h1234_5678, 32'hFFFF_FFFF, 5'd6, 32'h0, 1'b1, w);
    set_idle();
    @(negedge clk);
    check_output("illegal_sgnj_op", 32'(bus.sgnj_op), 32'd0);
    check_output("illegal_sgnj_rs1", bus.sgnj_rs1, 32'h1234_5678);
    check_output("illegal_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("idle_sgnj_rs1", bus.sgnj_rs1, 32'h0);
    check_output("idle_sgnj_op", 32'(bus.sgnj_op), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("idle_hold_wb_rd", 32'(bus.wb_rd), 32'd6);
    check_output("idle_hold_wb_illegal", 32'(bus.wb_illegal), 32'd1);
    check_output("count_after_4", 32'(op_count), 32'd4);
    @(posedge clk);
    #1;

    // Stall: two in the FIFO, one in the issue register, fourth held off
    bus.wb_ready = 1'b0;
    apply_stimulus(3'b000, 32'h4049_0FDB, 32'h0000_0000, 5'd7, 32'h4049_0FDB, 1'b0, w);
    apply_stimulus(3'b001, 32'h4049_0FDB, 32'h0000_0000, 5'd8, 32'hC049_0FDB, 1'b0, w);
    apply_stimulus(3'b010, 32'hC000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, 1'b0, w);
    bus.in_funct3 = 3'b000;
    bus.in_rs1    = 32'h7F80_0000;
    bus.in_rs2    = 32'h8000_0001;
    bus.in_rd     = 5'd10;
    @(negedge clk);
    check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("stall_busy", 32'(busy), 32'd1);
    check_output("stall_wb_valid", 32'(bus.wb_valid), 32'd1);
    check_output("stall_wb_data", bus.wb_data, 32'h4049_0FDB);
    @(negedge clk);
    check_output("stall_hold_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("stall_hold_wb_rd", 32'(bus.wb_rd), 32'd7);
    @(posedge clk);
    #1;

    // Full FIFO with a pop in the same cycle still accepts, then full-rate streaming
    bus.wb_ready = 1'b1;
    apply_stimulus(3'b000, 32'h7F80_0000, 32'h8000_0001, 5'd10, 32'hFF80_0000, 1'b0, w);
    check_output("full_pop_wait", 32'(w), 32'd0);
    apply_stimulus(3'b111, 32'h0000_0001, 32'h0000_0001, 5'd11, 32'h0, 1'b1, w);
    check_output("stream_wait1", 32'(w), 32'd0);
    apply_stimulus(3'b001, 32'h0000_0000, 32'h0000_0000, 5'd12, 32'h8000_0000, 1'b0, w);
    check_output("stream_wait2", 32'(w), 32'd0);
    set_idle();
    drain();
    check_output("count_after_10", 32'(op_count), 32'd10);

    // Reset with three ops in flight
    bus.wb_ready = 1'b0;
    apply_stimulus(3'b000, 32'h1111_1111, 32'h8000_0000, 5'd13, 32'h9111_1111, 1'b0, w);
    apply_stimulus(3'b000, 32'h2222_2222, 32'h8000_0000, 5'd14, 32'hA222_2222, 1'b0, w);
    apply_stimulus(3'b000, 32'h3333_3333, 32'h8000_0000, 5'd15, 32'hB333_3333, 1'b0, w);
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_op_count", 32'(op_count), 32'd0);
    check_output("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("midrst_wb_data", bus.wb_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wb_ready = 1'b1;

    // Operation resumes cleanly after the flush
    apply_stimulus(3'b010, 32'h0000_0001, 32'h8000_0000, 5'd31, 32'h8000_0001, 1'b0, w);
    set_idle();
    drain();
    check_output("count_after_rst", 32'(op_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
